// File: rtl/sound_pkg.sv
// Shared constants for the sound block: frame-sequencer timing, step-to-tick
// decode masks, channel indices and the master power state.
package sound_pkg;

    localparam int CLKS_PER_STEP_DEF = 64453;
    localparam int DIV_W_DEF         = 17;

    // Bit n set means the tick fires when the TC of step n is reached.
    localparam logic [7:0] LEN_STEPS   = 8'b0101_0101;
    localparam logic [7:0] SWEEP_STEPS = 8'b0100_0100;
    localparam logic [7:0] ENV_STEPS   = 8'b1000_0000;

    localparam int CH1    = 0;
    localparam int CH2    = 1;
    localparam int CH3    = 2;
    localparam int CH4    = 3;
    localparam int NUM_CH = 4;

    typedef enum logic {
        PWR_OFF = 1'b0,
        PWR_ON  = 1'b1
    } pwr_state_e;

    function automatic logic step_hit(input logic [7:0] mask, input logic [2:0] step);
        return mask[step];
    endfunction

endpackage

// File: rtl/sound_ch_status.sv
// One NR52 channel-active bit: power and DAC clear it, trigger sets it,
// length expiry clears it, otherwise it holds.
module sound_ch_status (
    input  logic i_clk,
    input  logic i_reset_l,
    input  logic i_power,
    input  logic i_dac_on,
    input  logic i_trigger,
    input  logic i_len_done,
    output logic o_active
);

    logic r_active;

    always_ff @(posedge i_clk) begin
        if (!i_reset_l) begin
            r_active <= 1'b0;
        end else if (!i_power || !i_dac_on) begin
            r_active <= 1'b0;
        end else if (i_trigger) begin
            r_active <= 1'b1;
        end else if (i_len_done) begin
            r_active <= 1'b0;
        end
    end

    assign o_active = r_active;

endmodule

// File: rtl/sound_frame_sequencer.sv
// Frame sequencer: divides the sound clock into 512 Hz steps, issues the
// length/sweep/envelope ticks and owns the NR52 power state and status bits.
module sound_frame_sequencer
    import sound_pkg::*;
#(
    parameter int CLKS_PER_STEP = CLKS_PER_STEP_DEF,
    parameter int DIV_W         = DIV_W_DEF
) (
    input  logic       I_CLK,
    input  logic       I_RESET_L,
    input  logic       I_APU_EN,
    input  logic [3:0] I_CH_TRIGGER,
    input  logic [3:0] I_CH_DAC_ON,
    input  logic [3:0] I_CH_LEN_DONE,
    output logic       O_LEN_TICK,
    output logic       O_SWEEP_TICK,
    output logic       O_ENV_TICK,
    output logic [2:0] O_STEP,
    output logic [3:0] O_CH_ACTIVE,
    output logic       O_CH_RESET_L
);

    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(CLKS_PER_STEP - 1);

    pwr_state_e       r_state;
    pwr_state_e       w_state_next;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_next;
    logic [2:0]       r_step;
    logic [2:0]       w_step_next;
    logic             r_len_tick;
    logic             r_sweep_tick;
    logic             r_env_tick;
    logic             w_len_next;
    logic             w_sweep_next;
    logic             w_env_next;
    logic             w_run;
    logic             w_tc;

    always_ff @(posedge I_CLK) begin
        if (!I_RESET_L) begin
            r_state      <= PWR_OFF;
            r_div        <= '0;
            r_step       <= 3'd0;
            r_len_tick   <= 1'b0;
            r_sweep_tick <= 1'b0;
            r_env_tick   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_div        <= w_div_next;
            r_step       <= w_step_next;
            r_len_tick   <= w_len_next;
            r_sweep_tick <= w_sweep_next;
            r_env_tick   <= w_env_next;
        end
    end

    // Running requires both the registered and the incoming enable, so a
    // falling enable clears the divider, step and any pending tick at once.
    always_comb begin
        w_state_next = I_APU_EN ? PWR_ON : PWR_OFF;
        w_run        = (r_state == PWR_ON) && (w_state_next == PWR_ON);
        w_tc         = (r_div == DIV_TC);
        w_div_next   = '0;
        w_step_next  = 3'd0;
        w_len_next   = 1'b0;
        w_sweep_next = 1'b0;
        w_env_next   = 1'b0;
        if (w_run) begin
            if (w_tc) begin
                w_step_next  = r_step + 3'd1;
                w_len_next   = step_hit(LEN_STEPS, r_step);
                w_sweep_next = step_hit(SWEEP_STEPS, r_step);
                w_env_next   = step_hit(ENV_STEPS, r_step);
            end else begin
                w_div_next  = r_div + DIV_W'(1);
                w_step_next = r_step;
            end
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        sound_ch_status u_status (
            .i_clk      (I_CLK),
            .i_reset_l  (I_RESET_L),
            .i_power    (w_run),
            .i_dac_on   (I_CH_DAC_ON[ch]),
            .i_trigger  (I_CH_TRIGGER[ch]),
            .i_len_done (I_CH_LEN_DONE[ch]),
            .o_active   (O_CH_ACTIVE[ch])
        );
    end

    assign O_LEN_TICK   = r_len_tick;
    assign O_SWEEP_TICK = r_sweep_tick;
    assign O_ENV_TICK   = r_env_tick;
    assign O_STEP       = r_step;
    assign O_CH_RESET_L = (r_state == PWR_ON);

endmodule

// File: tb/tb_sound_frame_sequencer.sv
// Self-checking bench for sound_frame_sequencer with CLKS_PER_STEP = 4.
module tb_sound_frame_sequencer;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       apu_en = 1'b0;
    logic [3:0] trig = 4'b0;
    logic [3:0] dac = 4'b0;
    logic [3:0] ld = 4'b0;
    logic       len_tick;
    logic       sweep_tick;
    logic       env_tick;
    logic [2:0] step;
    logic [3:0] active;
    logic       ch_rst_l;

    int n_checks = 0;
    int n_errors = 0;

    sound_frame_sequencer #(
        .CLKS_PER_STEP (4),
        .DIV_W         (3)
    ) dut (
        .I_CLK         (clk),
        .I_RESET_L     (rst_l),
        .I_APU_EN      (apu_en),
        .I_CH_TRIGGER  (trig),
        .I_CH_DAC_ON   (dac),
        .I_CH_LEN_DONE (ld),
        .O_LEN_TICK    (len_tick),
        .O_SWEEP_TICK  (sweep_tick),
        .O_ENV_TICK    (env_tick),
        .O_STEP        (step),
        .O_CH_ACTIVE   (active),
        .O_CH_RESET_L  (ch_rst_l)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Reference model of the whole block, used by the long random run.
    int         m_div = 0;
    int         m_step = 0;
    logic       m_en_q = 1'b0;
    logic       m_len = 1'b0;
    logic       m_sweep = 1'b0;
    logic       m_env = 1'b0;
    logic [3:0] m_active = 4'b0;
    logic       m_run;
    logic       m_tc;

    assign m_run = m_en_q && apu_en;
    assign m_tc  = (m_div == 3);

    always @(posedge clk) begin
        if (!rst_l) begin
            m_div    <= 0;
            m_step   <= 0;
            m_en_q   <= 1'b0;
            m_len    <= 1'b0;
            m_sweep  <= 1'b0;
            m_env    <= 1'b0;
            m_active <= 4'b0;
        end else begin
            m_len   <= m_run && m_tc && (m_step % 2 == 0);
            m_sweep <= m_run && m_tc && (m_step % 4 == 2);
            m_env   <= m_run && m_tc && (m_step == 7);
            if (!m_run) begin
                m_div  <= 0;
                m_step <= 0;
            end else if (m_tc) begin
                m_div  <= 0;
                m_step <= (m_step + 1) % 8;
            end else begin
                m_div <= m_div + 1;
            end
            for (int n = 0; n < 4; n++) begin
                if (!m_run || !dac[n]) m_active[n] <= 1'b0;
                else if (trig[n])      m_active[n] <= 1'b1;
                else if (ld[n])        m_active[n] <= 1'b0;
            end
            m_en_q <= apu_en;
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_reset(input string name);
        check({name, "_len"}, len_tick, 0);
        check({name, "_sweep"}, sweep_tick, 0);
        check({name, "_env"}, env_tick, 0);
        check({name, "_step"}, step, 0);
        check({name, "_active"}, active, 0);
        check({name, "_ch_rst_l"}, ch_rst_l, 0);
    endtask

    // Table-driven channel-status vectors
    typedef struct {
        logic       en;
        logic [3:0] dac;
        logic [3:0] trig;
        logic [3:0] ld;
        logic [3:0] exp_active;
        logic       exp_rst_l;
        string      name;
    } vec_t;

    vec_t vecs[12];

    // Scoreboard for the random run
    logic [10:0] exp_q[$];

    initial begin
        logic        prev_len;
        logic [10:0] exp_v;
        logic [10:0] act_v;

        vecs[0]  = '{1'b1, 4'b1111, 4'b0001, 4'b0000, 4'b0001, 1'b1, "trig_ch1"};
        vecs[1]  = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1'b1, "hold_ch1"};
        vecs[2]  = '{1'b1, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 1'b1, "len_done_ch1"};
        vecs[3]  = '{1'b1, 4'b1111, 4'b0001, 4'b0001, 4'b0001, 1'b1, "trig_beats_len"};
        vecs[4]  = '{1'b1, 4'b1011, 4'b1111, 4'b0000, 4'b1011, 1'b1, "dac_mask_trig"};
        vecs[5]  = '{1'b1, 4'b1010, 4'b0000, 4'b0000, 4'b1010, 1'b1, "dac_clear_ch1"};
        vecs[6]  = '{1'b1, 4'b1010, 4'b0000, 4'b1000, 4'b0010, 1'b1, "len_done_ch4"};
        vecs[7]  = '{1'b1, 4'b1111, 4'b0100, 4'b0010, 4'b0100, 1'b1, "indep_channels"};
        vecs[8]  = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, "power_off_trig"};
        vecs[9]  = '{1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b1, "power_on_edge"};
        vecs[10] = '{1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 1'b1, "trig_all"};
        vecs[11] = '{1'b1, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 1'b1, "len_done_all"};

        // Reset state, including enable held high under reset
        repeat (3) tick();
        check_all_reset("reset");
        apu_en = 1'b1;
        tick();
        check("reset_overrides_en", ch_rst_l, 0);

        // Basic cadence: cycle 0 is the first cycle with the enable registered
        rst_l = 1'b1;
        tick();
        check("cad_c0_ch_rst_l", ch_rst_l, 1);
        check("cad_c0_step", step, 0);
        for (int c = 1; c <= 40; c++) begin
            tick();
            check("cad_len", len_tick, (c == 4 || c == 12 || c == 20 || c == 28 || c == 36));
            check("cad_sweep", sweep_tick, (c == 12 || c == 28));
            check("cad_env", env_tick, (c == 32));
            check("cad_step", step, (c / 4) % 8);
        end

        // Reset mid-step at step 5, div 2 (cycle 54)
        for (int c = 41; c <= 54; c++) tick();
        check("mid_step_pre", step, 5);
        rst_l = 1'b0;
        tick();
        check_all_reset("mid_reset");

        // Restart, trigger ch1, then drop enable in the TC cycle of step 2
        rst_l = 1'b1;
        tick();
        check("restart_ch_rst_l", ch_rst_l, 1);
        dac = 4'b1111;
        for (int k = 1; k <= 11; k++) begin
            trig = (k == 1) ? 4'b0001 : 4'b0000;
            tick();
            check("restart_len", len_tick, (k == 4));
            if (k == 1) check("restart_trig_ch1", active, 4'b0001);
        end
        trig = 4'b0000;
        check("pwr_off_pre_step", step, 2);
        apu_en = 1'b0;
        tick();
        check_all_reset("pwr_off");
        trig = 4'b1111;
        tick();
        trig = 4'b0000;
        check("off_trig_ignored", active, 0);
        tick();
        check("off_trig_still_0", active, 0);

        // Power back on, then channel-status table
        apu_en = 1'b1;
        tick();
        check("table_pre_active", active, 0);
        for (int i = 0; i < 12; i++) begin
            apu_en = vecs[i].en;
            dac    = vecs[i].dac;
            trig   = vecs[i].trig;
            ld     = vecs[i].ld;
            tick();
            check({vecs[i].name, "_active"}, active, vecs[i].exp_active);
            check({vecs[i].name, "_ch_rst_l"}, ch_rst_l, vecs[i].exp_rst_l);
        end
        trig = 4'b0000;
        ld   = 4'b0000;

        // Long random run against the reference model
        prev_len = len_tick;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 99) == 0) apu_en = ~apu_en;
            rst_l = ($urandom_range(0, 999) != 0);
            if ($urandom_range(0, 49) == 0) dac = 4'($urandom_range(0, 15));
            for (int b = 0; b < 4; b++) begin
                trig[b] = ($urandom_range(0, 7) == 0);
                ld[b]   = ($urandom_range(0, 7) == 0);
            end
            tick();
            exp_q.push_back({m_len, m_sweep, m_env, 3'(m_step), m_active, m_en_q});
            act_v = {len_tick, sweep_tick, env_tick, step, active, ch_rst_l};
            exp_v = exp_q.pop_front();
            check("rand_outputs", act_v, exp_v);
            check("rand_len_width", prev_len & len_tick, 0);
            check("rand_sweep_needs_len", sweep_tick & ~len_tick, 0);
            prev_len = len_tick;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
